// File: rtl/sgdmac_pkg.sv
// Shared types and AXI constants for the SG DMA read-port multiplexer.
package sgdmac_pkg;

  localparam int SG_ADDR_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR      = 2'b01;

  typedef struct packed {
    logic [SG_ADDR_W-1:0] addr;
    logic [3:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_req_t;

endpackage

// File: rtl/sgdmac_rr_picker.sv
// Round-robin picker: first eligible requester at or after the pointer,
// pointer moves past the winner whenever the grant is consumed.
module sgdmac_rr_picker #(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         elig_i,
  input  logic                      advance_i,
  output logic                      any_o,
  output logic [NUM_CH-1:0]         gnt_o,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx_o
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;
  logic [IDX_W-1:0] idx_s;

  // cyclic scan starting at the pointer; sum is wide enough for ptr + NUM_CH - 1
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (sum_s >= (IDX_W+1)'(NUM_CH)) begin
        cand_s = IDX_W'(sum_s - (IDX_W+1)'(NUM_CH));
      end else begin
        cand_s = sum_s[IDX_W-1:0];
      end
      if (!found_s && elig_i[cand_s]) begin
        found_s = 1'b1;
        idx_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // one-hot view of the winning index
  always_comb begin
    gnt_o = '0;
    if (found_s) begin
      gnt_o[idx_s] = 1'b1;
    end else begin
      gnt_o = '0;
    end
  end

  assign any_o     = found_s;
  assign gnt_idx_o = idx_s;

  // pointer advances past the winner, wrapping at the last channel
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i) begin
      if (idx_s == IDX_W'(NUM_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = idx_s + IDX_W'(1'b1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/sgdmac_axi_rd_mux.sv
// N-channel AXI3 read-port multiplexer: round-robin AR arbitration with a
// registered AR stage, per-channel outstanding limits and R demux by ID.
module sgdmac_axi_rd_mux
  import sgdmac_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_arvalid_i,
  output logic [NUM_CH-1:0]        ch_arready_o,
  input  logic [NUM_CH*ADDR_W-1:0] ch_araddr_i,
  input  logic [NUM_CH*4-1:0]      ch_arlen_i,
  input  logic [NUM_CH*3-1:0]      ch_arsize_i,
  input  logic [NUM_CH*2-1:0]      ch_arburst_i,
  output logic [ID_W-1:0]          arid_o,
  output logic [ADDR_W-1:0]        araddr_o,
  output logic [3:0]               arlen_o,
  output logic [2:0]               arsize_o,
  output logic [1:0]               arburst_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,
  input  logic [ID_W-1:0]          rid_i,
  input  logic [DATA_W-1:0]        rdata_i,
  input  logic [1:0]               rresp_i,
  input  logic                     rlast_i,
  input  logic                     rvalid_i,
  output logic                     rready_o,
  output logic [NUM_CH-1:0]        ch_rvalid_o,
  input  logic [NUM_CH-1:0]        ch_rready_i,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic [1:0]               ch_rresp_o,
  output logic                     ch_rlast_o,
  output logic                     err_o,
  output logic [ID_W-1:0]          err_id_o,
  output logic                     outst_busy_o
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  if ((NUM_CH < 2) || (NUM_CH > 16) || (NUM_CH > (1 << ID_W)) ||
      (MAX_OUTST < 1) || (MAX_OUTST > 15) || (ADDR_W > SG_ADDR_W)) begin : g_bad_cfg
    $error("sgdmac_axi_rd_mux: unsupported parameter combination");
  end

  logic [NUM_CH-1:0] elig_s, gnt_s, inc_s, dec_s, rsel_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              any_s, stage_free_s, grant_s, r_hit_s, busy_s;
  ar_req_t           req_s;

  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  ar_req_t           ar_q, ar_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic              err_q, err_d;
  logic [ID_W-1:0]   err_id_q, err_id_d;

  // eligibility, R routing select and busy summary, all from the counters
  always_comb begin
    elig_s = '0;
    rsel_s = '0;
    busy_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      elig_s[k] = ch_arvalid_i[k] && (cnt_q[k] < CNT_W'(MAX_OUTST));
      rsel_s[k] = (rid_i == ID_W'(k)) && (cnt_q[k] != '0);
      busy_s    = busy_s | (cnt_q[k] != '0);
    end
  end

  sgdmac_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .clk       (clk),
    .rst       (rst),
    .elig_i    (elig_s),
    .advance_i (grant_s),
    .any_o     (any_s),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s)
  );

  assign stage_free_s = !arvalid_q || arready_i;
  assign grant_s      = !rst && stage_free_s && any_s;
  assign ch_arready_o = grant_s ? gnt_s : '0;
  assign inc_s        = grant_s ? gnt_s : '0;

  // AND-OR mux of the granted channel's request fields
  always_comb begin
    req_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      req_s.addr  = req_s.addr  | (SG_ADDR_W'(ch_araddr_i[k*ADDR_W +: ADDR_W]) & {SG_ADDR_W{gnt_s[k]}});
      req_s.len   = req_s.len   | (ch_arlen_i[k*4 +: 4]   & {4{gnt_s[k]}});
      req_s.size  = req_s.size  | (ch_arsize_i[k*3 +: 3]  & {3{gnt_s[k]}});
      req_s.burst = req_s.burst | (ch_arburst_i[k*2 +: 2] & {2{gnt_s[k]}});
    end
  end

  // AR output stage: load on grant, drop after handshake, otherwise hold
  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    ar_d      = ar_q;
    if (grant_s) begin
      arvalid_d = 1'b1;
      arid_d    = ID_W'(gnt_idx_s);
      ar_d      = req_s;
    end else if (arready_i) begin
      arvalid_d = 1'b0;
    end else begin
      arvalid_d = arvalid_q;
    end
  end

  // R demux: expected beats go to their channel, everything else is drained
  assign r_hit_s     = |rsel_s;
  assign ch_rvalid_o = rsel_s & {NUM_CH{rvalid_i}};
  assign rready_o    = r_hit_s ? |(rsel_s & ch_rready_i) : 1'b1;
  assign ch_rdata_o  = rdata_i;
  assign ch_rresp_o  = rresp_i;
  assign ch_rlast_o  = rlast_i;
  assign dec_s       = rsel_s & ch_rready_i & {NUM_CH{rvalid_i & rlast_i}};

  // outstanding counters; simultaneous issue and completion cancel out
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      case ({inc_s[k], dec_s[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1'b1);
        2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1'b1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  // sticky error captures only the first unexpected beat's id
  always_comb begin
    err_d    = err_q;
    err_id_d = err_id_q;
    if (rvalid_i && !r_hit_s && !err_q) begin
      err_d    = 1'b1;
      err_id_d = rid_i;
    end else begin
      err_d    = err_q;
      err_id_d = err_id_q;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      ar_q      <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      ar_q      <= ar_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign arvalid_o    = arvalid_q;
  assign arid_o       = arid_q;
  assign araddr_o     = ar_q.addr[ADDR_W-1:0];
  assign arlen_o      = ar_q.len;
  assign arsize_o     = ar_q.size;
  assign arburst_o    = ar_q.burst;
  assign err_o        = err_q;
  assign err_id_o     = err_id_q;
  assign outst_busy_o = busy_s;

endmodule

// File: tb/tb_sgdmac_axi_rd_mux.sv
// Bench for sgdmac_axi_rd_mux: directed scenarios plus random traffic,
// all checked against a transaction-level model of arbitration and counters.
module tb_sgdmac_axi_rd_mux;
  import sgdmac_pkg::*;

  localparam int NC = 4;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   ch_arvalid, ch_arready_o;
  logic [NC*AW-1:0] ch_araddr;
  logic [NC*4-1:0] ch_arlen;
  logic [NC*3-1:0] ch_arsize;
  logic [NC*2-1:0] ch_arburst;
  logic [IW-1:0]   arid_o;
  logic [AW-1:0]   araddr_o;
  logic [3:0]      arlen_o;
  logic [2:0]      arsize_o;
  logic [1:0]      arburst_o;
  logic            arvalid_o, arready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready_o;
  logic [NC-1:0]   ch_rvalid_o, ch_rready;
  logic [DW-1:0]   ch_rdata_o;
  logic [1:0]      ch_rresp_o;
  logic            ch_rlast_o, err_o, outst_busy_o;
  logic [IW-1:0]   err_id_o;

  always #5 clk = ~clk;

  sgdmac_axi_rd_mux #(.NUM_CH(NC), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst),
    .ch_arvalid_i(ch_arvalid), .ch_arready_o(ch_arready_o), .ch_araddr_i(ch_araddr),
    .ch_arlen_i(ch_arlen), .ch_arsize_i(ch_arsize), .ch_arburst_i(ch_arburst),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid),
    .rready_o(rready_o), .ch_rvalid_o(ch_rvalid_o), .ch_rready_i(ch_rready),
    .ch_rdata_o(ch_rdata_o), .ch_rresp_o(ch_rresp_o), .ch_rlast_o(ch_rlast_o),
    .err_o(err_o), .err_id_o(err_id_o), .outst_busy_o(outst_busy_o)
  );

  // reference model state
  int         m_cnt [NC];
  int         m_rr;
  bit         m_arvalid;
  int         m_arid;
  logic [AW-1:0] m_addr;
  logic [3:0] m_len;
  logic [2:0] m_size;
  logic [1:0] m_burst;
  bit         m_err;
  int         m_err_id;

  int n_cmp = 0;
  int n_err = 0;
  bit log_en = 1'b0;
  int gnt_log[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    ch_arvalid = '0; arready = 1'b1;
    rid = '0; rdata = '0; rresp = AXI_RESP_OKAY; rlast = 1'b0; rvalid = 1'b0; ch_rready = '0;
  endtask

  task automatic set_req(input int ch, input logic [31:0] addr, input logic [3:0] len);
    ch_araddr[ch*AW +: AW] = addr;
    ch_arlen[ch*4 +: 4]    = len;
    ch_arsize[ch*3 +: 3]   = 3'd2;
    ch_arburst[ch*2 +: 2]  = BURST_INCR;
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    int g;
    int c;
    bit hit;
    bit busy;
    logic [NC-1:0] exp_ar;
    logic [NC-1:0] exp_rv;
    logic exp_rr;
    #1;
    g = -1;
    if (!rst && (!m_arvalid || arready)) begin
      for (int i = 0; i < NC; i++) begin
        c = (m_rr + i) % NC;
        if (g < 0 && ch_arvalid[c] && m_cnt[c] < MO) g = c;
      end
    end
    exp_ar = '0;
    if (g >= 0) exp_ar[g] = 1'b1;
    check_eq("ch_arready", ch_arready_o, exp_ar);
    if (log_en) begin
      for (int i = 0; i < NC; i++) if (ch_arready_o[i]) gnt_log.push_back(i);
    end
    hit = (int'(rid) < NC) && (m_cnt[rid[1:0]] > 0);
    exp_rv = '0;
    if (hit && rvalid) exp_rv[rid[1:0]] = 1'b1;
    exp_rr = hit ? ch_rready[rid[1:0]] : 1'b1;
    check_eq("ch_rvalid", ch_rvalid_o, exp_rv);
    check_eq("rready", rready_o, exp_rr);
    check_eq("ch_rdata", ch_rdata_o, rdata);
    check_eq("ch_rresp", ch_rresp_o, rresp);
    check_eq("ch_rlast", ch_rlast_o, rlast);

    if (rst) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      m_rr = 0; m_arvalid = 1'b0; m_arid = 0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
      m_err = 1'b0; m_err_id = 0;
    end else begin
      if (g >= 0) begin
        m_arvalid = 1'b1; m_arid = g; m_rr = (g + 1) % NC; m_cnt[g]++;
        m_addr = ch_araddr[g*AW +: AW]; m_len = ch_arlen[g*4 +: 4];
        m_size = ch_arsize[g*3 +: 3];   m_burst = ch_arburst[g*2 +: 2];
      end else if (arready) begin
        m_arvalid = 1'b0;
      end
      if (hit && rvalid && rlast && ch_rready[rid[1:0]]) m_cnt[rid[1:0]]--;
      if (rvalid && !hit && !m_err) begin
        m_err = 1'b1; m_err_id = int'(rid);
      end
    end

    @(posedge clk);
    #1;
    busy = 1'b0;
    for (int i = 0; i < NC; i++) if (m_cnt[i] > 0) busy = 1'b1;
    check_eq("arvalid", arvalid_o, m_arvalid);
    if (m_arvalid) begin
      check_eq("arid", arid_o, m_arid);
      check_eq("araddr", araddr_o, m_addr);
      check_eq("arlen", arlen_o, m_len);
      check_eq("arsize", arsize_o, m_size);
      check_eq("arburst", arburst_o, m_burst);
    end
    check_eq("err", err_o, m_err);
    check_eq("err_id", err_id_o, m_err_id);
    check_eq("busy", outst_busy_o, busy);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int beats;
    int live[$];
    ch_araddr = '0; ch_arlen = '0; ch_arsize = '0; ch_arburst = '0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_rr = 0; m_arvalid = 1'b0; m_arid = 0; m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
    m_err = 1'b0; m_err_id = 0;
    do_reset();
    check_eq("rst_arvalid", arvalid_o, 1'b0);
    check_eq("rst_araddr", araddr_o, 32'h0);
    check_eq("rst_arid", arid_o, 4'h0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_busy", outst_busy_o, 1'b0);

    // single channel, two back-to-back requests
    set_req(2, 32'h1000, 4'd0); ch_arvalid = 4'b0100; step();
    check_eq("t1_arid_a", arid_o, 4'd2);
    check_eq("t1_addr_a", araddr_o, 32'h1000);
    set_req(2, 32'h2000, 4'd0); step();
    check_eq("t1_arid_b", arid_o, 4'd2);
    check_eq("t1_addr_b", araddr_o, 32'h2000);
    ch_arvalid = '0; step();
    check_eq("t1_busy", outst_busy_o, 1'b1);

    // three channels saturate their outstanding limits
    do_reset();
    set_req(0, 32'h100, 4'd1); set_req(1, 32'h200, 4'd2); set_req(3, 32'h300, 4'd3);
    ch_arvalid = 4'b1011; log_en = 1'b1;
    for (int i = 0; i < 15; i++) step();
    log_en = 1'b0;
    check_eq("t2_ngrants", gnt_log.size(), 12);
    for (int i = 0; i < gnt_log.size() && i < 12; i++) begin
      if (i % 3 == 0) check_eq("t2_order", gnt_log[i], 0);
      else if (i % 3 == 1) check_eq("t2_order", gnt_log[i], 1);
      else check_eq("t2_order", gnt_log[i], 3);
    end
    check_eq("t2_arvalid", arvalid_o, 1'b0);
    check_eq("t2_arready", ch_arready_o, 4'b0000);

    // AR backpressure holds the payload
    do_reset();
    set_req(1, 32'hA000, 4'd0); ch_arvalid = 4'b0010; arready = 1'b0; step();
    set_req(1, 32'hB000, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t3_hold_addr", araddr_o, 32'hA000);
      check_eq("t3_hold_id", arid_o, 4'd1);
    end
    arready = 1'b1; step();
    check_eq("t3_resume_addr", araddr_o, 32'hB000);

    // 4-beat burst on ch0 with a toggling channel ready
    do_reset();
    set_req(0, 32'h3000, 4'd3); ch_arvalid = 4'b0001; step();
    ch_arvalid = '0; step();
    beats = 0;
    for (int i = 0; i < 8; i++) begin
      rid = 4'd0; rvalid = 1'b1; rdata = $urandom; rlast = (beats == 3);
      ch_rready = {3'b000, 1'(i % 2)};
      step();
      if (ch_rready[0]) beats++;
    end
    idle(); step();
    check_eq("t4_busy", outst_busy_o, 1'b0);

    // unexpected ids: first one is captured, later ones ignored
    do_reset();
    rid = 4'd7; rvalid = 1'b1; rlast = 1'b1; step();
    check_eq("t5_err", err_o, 1'b1);
    check_eq("t5_err_id", err_id_o, 4'd7);
    rid = 4'd5; step();
    check_eq("t5_err_id_keep", err_id_o, 4'd7);
    idle(); step();

    // same-cycle issue and completion on ch2, then reset mid-burst
    do_reset();
    set_req(2, 32'h4000, 4'd0); ch_arvalid = 4'b0100; step();
    rid = 4'd2; rvalid = 1'b1; rlast = 1'b1; ch_rready = 4'b0100; step();
    idle(); step();
    check_eq("t6_busy", outst_busy_o, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("t6_rst_busy", outst_busy_o, 1'b0);
    check_eq("t6_rst_arvalid", arvalid_o, 1'b0);
    rid = 4'd2; rvalid = 1'b1; rlast = 1'b1; ch_rready = 4'b0100; step();
    check_eq("t6_stale_err", err_o, 1'b1);
    check_eq("t6_stale_id", err_id_o, 4'd2);
    idle();

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      ch_arvalid = 4'($urandom);
      ch_araddr  = {$urandom, $urandom, $urandom, $urandom};
      ch_arlen   = 16'($urandom);
      ch_arsize  = 12'($urandom);
      ch_arburst = 8'($urandom);
      arready    = ($urandom_range(0, 3) != 0);
      rvalid     = $urandom_range(0, 1);
      rdata      = $urandom;
      case ($urandom_range(0, 3))
        0: rresp = AXI_RESP_SLVERR;
        1: rresp = AXI_RESP_DECERR;
        default: rresp = AXI_RESP_OKAY;
      endcase
      rlast      = ($urandom_range(0, 2) == 0);
      ch_rready  = 4'($urandom);
      live.delete();
      for (int i = 0; i < NC; i++) if (m_cnt[i] > 0) live.push_back(i);
      if (live.size() > 0 && $urandom_range(0, 19) != 0)
        rid = IW'(live[$urandom_range(0, live.size() - 1)]);
      else
        rid = IW'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sgdmac_axi_rd_mux.md
Name: sgdmac_axi_rd_mux

Overview:
Parametrised N-channel AXI3 read-port multiplexer for the SG DMA engine. It replaces the fixed 2-channel AR arbiter and the rid-indexed rready routing with one block. Requestors are the descriptor fetcher, multiple read engines and future prefetchers. It provides round-robin AR arbitration, a registered AR output stage, per-channel outstanding-burst limiting, and R-channel demux by ID with drain-and-flag on unexpected responses.

Parameters:
NUM_CH, 4, number of requesting channels (2..16).
ID_W, 4, AXI ID width; NUM_CH <= 2**ID_W is required (elaboration-time assertion).
ADDR_W, 32, address width.
DATA_W, 32, R data width.
MAX_OUTST, 4, max in-flight bursts per channel (1..15).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ch_arvalid_i  in  NUM_CH  per-channel AR request
ch_arready_o  out  NUM_CH  per-channel AR accept
ch_araddr_i  in  NUM_CH*ADDR_W  packed addresses, channel k at [k*ADDR_W +: ADDR_W]
ch_arlen_i  in  NUM_CH*4  packed burst lengths
ch_arsize_i  in  NUM_CH*3  packed sizes
ch_arburst_i  in  NUM_CH*2  packed burst types
arid_o / araddr_o / arlen_o / arsize_o / arburst_o  out  ID_W/ADDR_W/4/3/2  AXI AR payload
arvalid_o  out  1  AXI AR valid
arready_i  in  1  AXI AR ready
rid_i  in  ID_W  AXI R id
rdata_i  in  DATA_W  AXI R data
rresp_i  in  2  AXI R response
rlast_i  in  1  AXI R last beat
rvalid_i  in  1  AXI R valid
rready_o  out  1  AXI R ready
ch_rvalid_o  out  NUM_CH  per-channel R valid (one-hot or zero)
ch_rready_i  in  NUM_CH  per-channel R ready
ch_rdata_o / ch_rresp_o / ch_rlast_o  out  DATA_W/2/1  shared R payload, broadcast to all channels
err_o  out  1  sticky protocol error
err_id_o  out  ID_W  rid of the first error event
outst_busy_o  out  1  any channel has a nonzero outstanding count

Behaviour:
- Reset (rst=1 at posedge): arvalid_o=0; AR payload=0; rr_ptr=0; all outstanding counters=0; err_o=0; err_id_o=0.
- Outputs driven from reset state: ch_arready_o=0, outst_busy_o=0. rready_o, ch_rvalid_o and ch_r*_o are combinational from R inputs.
- Eligibility: channel k is eligible when ch_arvalid_i[k]=1 and cnt[k] < MAX_OUTST.
- Stage free: out stage is free when arvalid_o=0, or when arvalid_o=1 and arready_i=1 in the same cycle. Back-to-back issue is allowed.
- Grant: when the stage is free and at least one channel is eligible, grant the first eligible channel at or after rr_ptr (cyclic).
  - ch_arready_o[g]=1 combinationally in that cycle; all other ch_arready_o bits=0.
  - Next cycle: arvalid_o=1, arid_o=g (zero-extended), payload=channel g's fields, rr_ptr=(g+1) mod NUM_CH, cnt[g]++.
- Latency: 1 cycle from ch_arvalid_i to arvalid_o. While arvalid_o=1 and arready_i=0, the payload and arvalid_o hold stable (AXI rule).
- No grant: arvalid_o drops after the handshake; rr_ptr is unchanged.
- R routing, rid_i < NUM_CH and cnt[rid_i] > 0: ch_rvalid_o[rid_i]=rvalid_i, rready_o=ch_rready_i[rid_i].
  - A handshake with rlast_i=1 decrements cnt[rid_i].
  - Same-cycle increment (grant) and decrement on one channel leaves the count unchanged.
- Unexpected response (rid_i >= NUM_CH, or cnt[rid_i]==0):
  - No ch_rvalid_o is asserted; rready_o=1 (beat is drained).
  - If err_o=0 on the beat's rvalid_i cycle, next cycle err_o=1 and err_id_o=rid_i; later events do not overwrite.
  - err_o clears only on reset.
- rresp_i is passed through unchanged; SLVERR/DECERR do not set err_o.
- Counter width is $clog2(MAX_OUTST+1); counts never wrap, because the grant is blocked at MAX_OUTST.
- Reset mid-operation: all in-flight state is discarded. R beats arriving after reset for pre-reset bursts are unexpected, drained, and flagged.
- rr_ptr wraps from NUM_CH-1 to 0.

Decomposition:
- sgdmac_pkg: ar_req_t struct {addr, len, size, burst} parametrised via localparams; constants AXI_RESP_OKAY/SLVERR/DECERR and BURST_INCR.
- Sub-module sgdmac_rr_picker: NUM_CH eligibility vector in, rr_ptr register, one-hot grant and binary index out, advance input. Pointer update is internal on advance.

Test Plan:
- Single channel 2 requests addr 0x1000 then 0x2000, arready_i=1 -> arvalid_o on cycles 1 and 2, arid_o=2 both times, cnt[2]=2, outst_busy_o=1.
- Channels 0,1,3 requesting continuously, arready_i=1, no R returns, MAX_OUTST=4 -> grant order 0,1,3,0,1,3,…; after 12 grants all ch_arready_o=0 and arvalid_o=0.
- arready_i held 0 for 5 cycles with ch1 granted -> arid_o=1 and araddr_o stable for 5 cycles, no further ch_arready_o; grant resumes the cycle after arready_i=1.
- ch0 4-beat burst outstanding, R beats rid=0 with ch_rready_i[0] toggling -> rready_o mirrors it, data reaches ch0 only, cnt[0]: 1→0 on rlast handshake.
- R beat rid=7 with NUM_CH=4 -> rready_o=1, no ch_rvalid_o, err_o=1 and err_id_o=7 next cycle; a later rid=5 event leaves err_id_o=7.
- Same-cycle ch2 grant and ch2 rlast handshake at cnt=1 -> cnt[2] stays 1; rst mid-burst -> all counters 0, arvalid_o=0 next cycle.
